// File: rtl/nandn_filt_if.sv
// ============================================================================
//  Module      : nandn_filt_if
//  Description : Signal bundle for the nandn_filt deglitched NAND brick.
//                Carries the NAND inputs, the filter enable and the three
//                observation/result outputs. Clock, reset and the supply
//                pins stay as plain ports on the brick itself.
//  Signals     : i      [N_IN] NAND inputs            (master -> slave)
//                en            filter enable           (master -> slave)
//                o             filtered NAND output    (slave -> master)
//                o_raw         unfiltered ~&i          (slave -> master)
//                chg           one-cycle change pulse  (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nandn_filt_if #(
    parameter int N_IN = 2
) ();

    logic [N_IN-1:0] i;
    logic            en;
    logic            o;
    logic            o_raw;
    logic            chg;

    // Master drives the inputs and observes the brick.
    modport master (
        output i,
        output en,
        input  o,
        input  o_raw,
        input  chg
    );

    // Slave is the NAND brick itself.
    modport slave (
        input  i,
        input  en,
        output o,
        output o_raw,
        output chg
    );

endinterface : nandn_filt_if

`default_nettype wire

// File: rtl/nandn_filt.sv
// ============================================================================
//  Module      : nandn_filt
//  Description : Parametrised N-input NAND brick with a registered,
//                deglitched output. The output only follows a new NAND value
//                once it has differed from the current output for FILT_CYC
//                consecutive rising edges of CELCLK.
//  Parameters  : N_IN     (2..16)  number of NAND inputs
//                FILT_CYC (1..255) consecutive mismatching edges before o
//                                  updates; 1 makes o a plain register
//  Ports       : CELCLK   clock, all state changes on the rising edge
//                CELRSTB  asynchronous active-low reset
//                CELV, CELG, SUB  supply / ground / substrate pins, no logic
//                nand_bus slave side of nandn_filt_if (i, en, o, o_raw, chg)
//  Config      : define CEL_NANDN_SYNC_EN to put a 2-flop synchroniser on
//                every bit of i (adds 2 edges of latency). Without it, i
//                must be synchronous to CELCLK.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nandn_filt #(
    parameter int N_IN     = 2,
    parameter int FILT_CYC = 4
) (
    input  wire logic    CELCLK,
    input  wire logic    CELRSTB,
    input  wire logic    CELV,
    input  wire logic    CELG,
    input  wire logic    SUB,
    nandn_filt_if.slave  nand_bus
);

    // Terminal count of the filter counter; the update happens on the edge
    // that sees this value together with a mismatch.
    localparam logic [7:0] c_CNT_LIM = 8'(FILT_CYC - 1);

    // Physical pins only; folded into a sink so they are visibly consumed.
    logic w_unused_pins;
    assign w_unused_pins = CELV ^ CELG ^ SUB;

    // ------------------------------------------------------------------
    // Input conditioning: raw_s is the NAND value the filter works on.
    // ------------------------------------------------------------------
    logic w_raw_s;

`ifdef CEL_NANDN_SYNC_EN
    logic [N_IN-1:0] sync1_q;
    logic [N_IN-1:0] sync2_q;

    // Reset to 0 gives raw_s = 1, which agrees with the reset value of o,
    // so no spurious count starts right after reset release.
    always_ff @(posedge CELCLK or negedge CELRSTB) begin
        if (!CELRSTB) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            // Keeps sampling regardless of en.
            sync1_q <= nand_bus.i;
            sync2_q <= sync1_q;
        end
    end

    assign w_raw_s = ~&sync2_q;
`else
    assign w_raw_s = ~&nand_bus.i;
`endif

    // ------------------------------------------------------------------
    // Filter state
    // ------------------------------------------------------------------
    logic       o_q;
    logic       o_d;
    logic       chg_q;
    logic       chg_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        o_d   = o_q;
        cnt_d = cnt_q;
        chg_d = 1'b0;
        if (!nand_bus.en) begin
            // Disabled: force high, drop any partial count. chg flags the
            // edge only when o actually rises.
            o_d   = 1'b1;
            cnt_d = 8'd0;
            chg_d = ~o_q;
        end else if (w_raw_s == o_q) begin
            // Mismatch ended (or never began): a glitch shorter than the
            // filter window leaves no trace.
            cnt_d = 8'd0;
        end else if (cnt_q == c_CNT_LIM) begin
            o_d   = w_raw_s;
            cnt_d = 8'd0;
            chg_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CELCLK or negedge CELRSTB) begin
        if (!CELRSTB) begin
            o_q   <= 1'b1;
            chg_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            o_q   <= o_d;
            chg_q <= chg_d;
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign nand_bus.o     = o_q;
    assign nand_bus.chg   = chg_q;
    // Observation tap straight from the pins, never from the synchroniser.
    assign nand_bus.o_raw = ~&nand_bus.i;

endmodule : nandn_filt

`default_nettype wire

// File: tb/tb_nandn_filt.sv
// ============================================================================
//  Module      : tb_nandn_filt
//  Description : Directed self-checking bench for nandn_filt. Three
//                instances: A (N_IN=2, FILT_CYC=4), B (N_IN=8, FILT_CYC=1),
//                C (N_IN=2, FILT_CYC=8). Expected edge positions account for
//                the 2 extra edges when CEL_NANDN_SYNC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nandn_filt;

`ifdef CEL_NANDN_SYNC_EN
    localparam int c_SL = 2;
`else
    localparam int c_SL = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic rst_c;

    nandn_filt_if #(.N_IN(2)) if_a ();
    nandn_filt_if #(.N_IN(8)) if_b ();
    nandn_filt_if #(.N_IN(2)) if_c ();

    nandn_filt #(.N_IN(2), .FILT_CYC(4)) u_a (
        .CELCLK   (clk),
        .CELRSTB  (rst_a),
        .CELV     (1'b1),
        .CELG     (1'b0),
        .SUB      (1'b0),
        .nand_bus (if_a)
    );

    nandn_filt #(.N_IN(8), .FILT_CYC(1)) u_b (
        .CELCLK   (clk),
        .CELRSTB  (rst_b),
        .CELV     (1'b1),
        .CELG     (1'b0),
        .SUB      (1'b0),
        .nand_bus (if_b)
    );

    nandn_filt #(.N_IN(2), .FILT_CYC(8)) u_c (
        .CELCLK   (clk),
        .CELRSTB  (rst_c),
        .CELV     (1'b1),
        .CELG     (1'b0),
        .SUB      (1'b0),
        .nand_bus (if_c)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and land 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int falls;
        int fall_at;

        // ---------------- reset / idle ----------------
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        if_a.i = 2'b11; if_a.en = 1'b1;
        if_b.i = 8'hFF; if_b.en = 1'b1;
        if_c.i = 2'b01; if_c.en = 1'b1;
        repeat (3) tick();
        chk("a_rst_o",     if_a.o,     1);
        chk("a_rst_chg",   if_a.chg,   0);
        chk("a_rst_o_raw", if_a.o_raw, 0);
        chk("b_rst_o",     if_b.o,     1);
        chk("c_rst_o",     if_c.o,     1);

        // Release between edges; the next rising edge is edge 0.
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int k = 0; k <= 3 + c_SL; k++) begin
            tick();
            chk("a_lat_o",   if_a.o,   (k == 3 + c_SL) ? 0 : 1);
            chk("a_lat_chg", if_a.chg, (k == 3 + c_SL) ? 1 : 0);
        end
        tick();
        chk("a_lat_chg_end", if_a.chg, 0);
        chk("a_lat_o_hold",  if_a.o,   0);

        // ---------------- glitch rejection (A) ----------------
        if_a.i = 2'b01;
        repeat (6 + c_SL) tick();
        chk("a_pre_glitch_o", if_a.o, 1);

        if_a.i = 2'b11;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) if_a.i = 2'b01;
            tick();
            chk("a_glitch3_o",   if_a.o,   1);
            chk("a_glitch3_chg", if_a.chg, 0);
        end

        if_a.i  = 2'b11;
        falls   = 0;
        fall_at = -1;
        for (int k = 0; k < 14; k++) begin
            if (k == 4) if_a.i = 2'b01;
            tick();
            if (if_a.chg && !if_a.o) begin
                falls++;
                if (fall_at < 0) fall_at = k;
            end
        end
        chk("a_pulse4_falls", falls,   1);
        chk("a_pulse4_at",    fall_at, 3 + c_SL);
        chk("a_pulse4_back",  if_a.o,  1);

        // ---------------- enable override (A) ----------------
        if_a.i = 2'b11;
        repeat (6 + c_SL) tick();
        chk("a_en_pre_o", if_a.o, 0);
        if_a.en = 1'b0;
        tick();
        chk("a_en_off_o",   if_a.o,   1);
        chk("a_en_off_chg", if_a.chg, 1);
        tick();
        chk("a_en_off_o2",   if_a.o,   1);
        chk("a_en_off_chg2", if_a.chg, 0);
        if_a.en = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            tick();
            chk("a_en_on_o",   if_a.o,   (k == 3) ? 0 : 1);
            chk("a_en_on_chg", if_a.chg, (k == 3) ? 1 : 0);
        end

        // Asynchronous reset with o=0, chg=1: must clear before any edge.
        #1 rst_a = 1'b0;
        #1;
        chk("a_async_rst_o",   if_a.o,   1);
        chk("a_async_rst_chg", if_a.chg, 0);
        rst_a = 1'b1;

        // ---------------- wide NAND (B, FILT_CYC=1) ----------------
        chk("b_pre_o", if_b.o, 0);
        if_b.i = 8'hFE;
        #1;
        chk("b_o_raw_imm", if_b.o_raw, 1);
        chk("b_o_hold",    if_b.o,     0);
        for (int k = 0; k <= c_SL; k++) begin
            tick();
            chk("b_step_o",   if_b.o,   (k == c_SL) ? 1 : 0);
            chk("b_step_chg", if_b.chg, (k == c_SL) ? 1 : 0);
        end
        tick();
        chk("b_chg_end", if_b.chg, 0);
        chk("b_o_end",   if_b.o,   1);

        // ---------------- reset mid-count (C, FILT_CYC=8) ----------------
        if_c.i = 2'b11;
        repeat (5 + c_SL) tick();
        chk("c_midcnt_o",   if_c.o,   1);
        chk("c_midcnt_chg", if_c.chg, 0);
        #1 rst_c = 1'b0;
        #1;
        chk("c_rst_async_o",   if_c.o,   1);
        chk("c_rst_async_chg", if_c.chg, 0);
        tick();
        rst_c = 1'b1;
        for (int k = 0; k <= 7 + c_SL; k++) begin
            tick();
            chk("c_recount_o", if_c.o, (k == 7 + c_SL) ? 0 : 1);
        end
        tick();
        chk("c_final_chg", if_c.chg, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_nandn_filt

`default_nettype wire
